// File: rtl/sram_march_bist.sv
// March C- self-test engine for one single-port masked SRAM macro. It owns the
// macro port while busy and otherwise passes the functional requester straight through.
`timescale 1ns/1ps
module sram_march_bist #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512,
    parameter int DATA_W = 8
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [DATA_W-1:0] fail_exp_o,
    output logic [DATA_W-1:0] fail_act_o,
    output logic [15:0]       err_count_o,
    input  logic [ADDR_W-1:0] func_addr_i,
    input  logic              func_en_i,
    input  logic              func_wmode_i,
    input  logic [DATA_W-1:0] func_wmask_i,
    input  logic [DATA_W-1:0] func_wdata_i,
    output logic [DATA_W-1:0] func_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_en_o,
    output logic              mem_wmode_o,
    output logic [DATA_W-1:0] mem_wmask_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] ONES      = {DATA_W{1'b1}};

    state_t            state_q, state_d;
    logic [2:0]        elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;   // 0: read slot, 1: write slot of a two-op element
    logic              cmp_valid_q, cmp_valid_d;
    logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
    logic [DATA_W-1:0] cmp_exp_q, cmp_exp_d;
    logic              fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_exp_q, fail_act_q;
    logic [15:0]       err_count_q;
    logic              clear_results;
    logic              two_op, reading, step, is_down, last_addr;
    logic [DATA_W-1:0] rd_exp, wr_data;

    always_comb begin
        state_d       = state_q;
        elem_d        = elem_q;
        addr_d        = addr_q;
        phase_d       = phase_q;
        cmp_valid_d   = 1'b0;
        cmp_addr_d    = cmp_addr_q;
        cmp_exp_d     = cmp_exp_q;
        clear_results = 1'b0;
        mem_addr_o    = func_addr_i;
        mem_en_o      = func_en_i;
        mem_wmode_o   = func_wmode_i;
        mem_wmask_o   = func_wmask_i;
        mem_wdata_o   = func_wdata_i;

        two_op    = (elem_q >= 3'd1) && (elem_q <= 3'd4);
        reading   = (elem_q == 3'd5) || (two_op && !phase_q);
        step      = !two_op || phase_q;
        is_down   = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_addr = is_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
        rd_exp    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? ONES : '0;
        wr_data   = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? ONES : '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d       = S_RUN;
                    elem_d        = 3'd0;
                    addr_d        = '0;
                    phase_d       = 1'b0;
                    clear_results = 1'b1;
                end
            end
            S_RUN: begin
                mem_addr_o  = addr_q;
                mem_en_o    = 1'b1;
                mem_wmode_o = !reading;
                mem_wmask_o = ONES;
                mem_wdata_o = wr_data;
                if (reading) begin
                    cmp_valid_d = 1'b1;
                    cmp_addr_d  = addr_q;
                    cmp_exp_d   = rd_exp;
                end
                if (two_op) begin
                    phase_d = !phase_q;
                end
                if (step) begin
                    if (!last_addr) begin
                        addr_d = is_down ? addr_q - 1'b1 : addr_q + 1'b1;
                    end else if (elem_q == 3'd5) begin
                        state_d = S_DRAIN;
                    end else begin
                        elem_d = elem_q + 3'd1;
                        // E3 and E4 walk downwards, so they start from the top word
                        addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_LAST : '0;
                    end
                end
            end
            S_DRAIN: begin
                mem_addr_o  = addr_q;
                mem_en_o    = 1'b0;
                mem_wmode_o = 1'b0;
                mem_wmask_o = '0;
                mem_wdata_o = '0;
                state_d     = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            elem_q      <= 3'd0;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            cmp_valid_q <= 1'b0;
            cmp_addr_q  <= '0;
            cmp_exp_q   <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_exp_q  <= '0;
            fail_act_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            cmp_valid_q <= cmp_valid_d;
            cmp_addr_q  <= cmp_addr_d;
            cmp_exp_q   <= cmp_exp_d;
            if (clear_results) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_exp_q  <= '0;
                fail_act_q  <= '0;
                err_count_q <= '0;
            end else if (cmp_valid_q && (mem_rdata_i != cmp_exp_q)) begin
                if (err_count_q != 16'hFFFF) begin
                    err_count_q <= err_count_q + 16'd1;
                end
                if (!fail_q) begin
                    fail_q      <= 1'b1;
                    fail_addr_q <= cmp_addr_q;
                    fail_exp_q  <= cmp_exp_q;
                    fail_act_q  <= mem_rdata_i;
                end
            end
        end
    end

    assign busy_o       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done_o       = (state_q == S_DONE);
    assign fail_o       = fail_q;
    assign fail_addr_o  = fail_addr_q;
    assign fail_exp_o   = fail_exp_q;
    assign fail_act_o   = fail_act_q;
    assign err_count_o  = err_count_q;
    assign func_rdata_o = mem_rdata_i;
endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: a faulty-SRAM model behind the BIST, with each run
// compared against a March C- reference walk over an array with the same stuck-at faults.
`timescale 1ns/1ps
module tb_sram_march_bist;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          reset, start;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_exp, fail_act;
    logic [15:0]   err_count;
    logic [AW-1:0] func_addr;
    logic          func_en, func_wmode;
    logic [DW-1:0] func_wmask, func_wdata, func_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_en, mem_wmode;
    logic [DW-1:0] mem_wmask, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem_arr [DEPTH];
    logic [DW-1:0] sa1 [DEPTH];
    logic [DW-1:0] sa0 [DEPTH];

    sram_march_bist #(.ADDR_W(AW), .DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clock_i(clk), .reset_i(reset), .start_i(start),
        .busy_o(busy), .done_o(done), .fail_o(fail),
        .fail_addr_o(fail_addr), .fail_exp_o(fail_exp), .fail_act_o(fail_act),
        .err_count_o(err_count),
        .func_addr_i(func_addr), .func_en_i(func_en), .func_wmode_i(func_wmode),
        .func_wmask_i(func_wmask), .func_wdata_i(func_wdata), .func_rdata_o(func_rdata),
        .mem_addr_o(mem_addr), .mem_en_o(mem_en), .mem_wmode_o(mem_wmode),
        .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Macro model: masked write, registered read, stuck-at bits applied on read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wmode)
                mem_arr[mem_addr] <= (mem_arr[mem_addr] & ~mem_wmask) | (mem_wdata & mem_wmask);
            else
                mem_rdata <= (mem_arr[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa1[i] = '0;
            sa0[i] = '0;
        end
    endtask

    // March C- walked element by element over a plain array with the fault map.
    task automatic ref_march(output int errs, output logic [AW-1:0] fa,
                             output logic [DW-1:0] fe, output logic [DW-1:0] fact);
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] v, rexp, wval;
        bit            first, down, has_rd, has_wr;
        int            a;
        errs = 0; fa = '0; fe = '0; fact = '0; first = 1'b1;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            down   = (e == 3) || (e == 4);
            has_rd = (e != 0);
            has_wr = (e != 5);
            rexp   = (e == 2 || e == 4) ? 8'hFF : 8'h00;
            wval   = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                a = down ? DEPTH - 1 - i : i;
                if (has_rd) begin
                    v = (m[a] | sa1[a]) & ~sa0[a];
                    if (v != rexp) begin
                        if (errs < 65535) errs++;
                        if (first) begin
                            first = 1'b0; fa = AW'(a); fe = rexp; fact = v;
                        end
                    end
                end
                if (has_wr) m[a] = wval;
            end
        end
    endtask

    task automatic randomize_func();
        func_addr  = AW'($urandom_range(0, DEPTH - 1));
        func_en    = 1'($urandom_range(0, 1));
        func_wmode = 1'($urandom_range(0, 1));
        func_wmask = DW'($urandom);
        func_wdata = DW'($urandom);
    endtask

    task automatic idle_func();
        func_en = 1'b0; func_wmode = 1'b0; func_addr = '0; func_wmask = '0; func_wdata = '0;
    endtask

    // One BIST run; reset_at > 0 aborts it with a reset at that busy cycle.
    task automatic run_test(input string name, input int reset_at, input bit pulse_mid);
        int            r_errs, cycles, en_cnt;
        logic [AW-1:0] r_fa;
        logic [DW-1:0] r_fe, r_fact;
        ref_march(r_errs, r_fa, r_fe, r_fact);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({name, ".busy_after_start"}, 32'(busy), 32'd1);
        check({name, ".cleared"}, {done, fail, 14'd0, err_count}, 32'd0);
        cycles = 0; en_cnt = 0;
        while (busy && cycles < 6000) begin
            if (mem_en) en_cnt++;
            cycles++;
            randomize_func();
            start = pulse_mid && (cycles == 100 || cycles == 4000);
            if (reset_at > 0 && cycles == reset_at) begin
                check({name, ".fail_before_reset"}, 32'(fail), 32'(r_errs > 0));
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                check({name, ".rst_flags"}, {busy, done, fail, 29'd0}, 32'd0);
                check({name, ".rst_err"}, 32'(err_count), 32'd0);
                check({name, ".rst_fail_addr"}, 32'(fail_addr), 32'd0);
                check({name, ".rst_mem_addr"}, 32'(mem_addr), 32'(func_addr));
                check({name, ".rst_mem_ctl"}, {mem_en, mem_wmode, mem_wmask, mem_wdata},
                      {func_en, func_wmode, func_wmask, func_wdata});
                idle_func();
                $display("run %s: reset at busy cycle %0d", name, reset_at);
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        idle_func();
        check({name, ".busy_cycles"}, 32'(cycles), 32'd5121);
        check({name, ".mem_en_cycles"}, 32'(en_cnt), 32'd5120);
        check({name, ".done"}, {busy, done}, 32'b01);
        check({name, ".fail"}, 32'(fail), 32'(r_errs > 0));
        check({name, ".err_count"}, 32'(err_count), 32'(r_errs));
        check({name, ".fail_addr"}, 32'(fail_addr), 32'(r_fa));
        check({name, ".fail_exp_act"}, {fail_exp, fail_act}, {r_fe, r_fact});
        $display("run %s: busy=%0d errs=%0d fail_addr=0x%0h exp=0x%0h act=0x%0h",
                 name, cycles, err_count, fail_addr, fail_exp, fail_act);
    endtask

    initial begin
        int n;
        int a;
        reset = 1'b1; start = 1'b0;
        idle_func();
        clear_faults();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        func_addr = 9'h123;
        #1;
        check("reset.flags", {busy, done, fail, 29'd0}, 32'd0);
        check("reset.fail_info", {fail_addr, fail_exp, fail_act}, 32'd0);
        check("reset.err_count", 32'(err_count), 32'd0);
        check("reset.passthru_addr", 32'(mem_addr), 32'h123);

        // Idle passthrough: full write, read back, then a masked write over it.
        @(negedge clk); func_en = 1; func_wmode = 1; func_addr = 9'h033; func_wmask = 8'hFF; func_wdata = 8'hA5;
        @(negedge clk); func_wmode = 0;
        @(negedge clk); func_en = 0;
        check("idle.rdata", 32'(func_rdata), 32'hA5);
        check("idle.busy", 32'(busy), 32'd0);
        $display("idle read 0x033 -> 0x%0h", func_rdata);
        func_en = 1; func_wmode = 1; func_wmask = 8'h0F; func_wdata = 8'h3C;
        @(negedge clk); func_wmode = 0;
        @(negedge clk); func_en = 0;
        check("idle.masked_rdata", 32'(func_rdata), 32'hAC);
        $display("idle masked read 0x033 -> 0x%0h", func_rdata);
        idle_func();

        run_test("clean", 0, 1'b0);

        sa1[9'h05A] = 8'h08;
        run_test("sa1_05A", 0, 1'b0);
        check("sa1_05A.known", {fail_addr, 7'd0, fail_exp, fail_act}, {9'h05A, 7'd0, 8'h00, 8'h08});
        check("sa1_05A.known_errs", 32'(err_count), 32'd3);

        clear_faults();
        run_test("restart_from_done", 0, 1'b1);

        sa1[9'h010] = 8'h01;
        sa1[9'h1F0] = 8'h01;
        run_test("two_faults", 0, 1'b0);
        check("two_faults.first", 32'(fail_addr), 32'h010);

        clear_faults();
        sa1[9'h05A] = 8'h08;
        run_test("reset_mid", 2000, 1'b0);
        run_test("after_reset", 0, 1'b0);

        for (int t = 0; t < 3; t++) begin
            clear_faults();
            n = $urandom_range(0, 3);
            for (int k = 0; k < n; k++) begin
                a = $urandom_range(0, DEPTH - 1);
                sa1[a] = sa1[a] | DW'($urandom);
                sa0[a] = sa0[a] | (DW'($urandom) & ~sa1[a]);
            end
            run_test($sformatf("random%0d", t), 0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
